pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Generates per-register hold and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB flops, plus PC hold and redirect.
- Merges memory-busy stalls, load-use hazards, branch-mispredict flushes resolved in MEM, and halt drain into one prioritised policy.
- Replaces the ad-hoc per-flop stall/flush terms.

---
 rtl/pipe_hazard_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: per-flop hold/flush, PC hold/redirect, halt drain.
// Optional performance counters are compiled in when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
   parameter int unsigned REG_W         = 3,
   parameter int unsigned DRAIN_CYCLES  = 2,
   parameter int unsigned STALL_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fetch_stall,
   input  logic             mem_stall,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_rs_used,
   input  logic             id_rt_used,
   input  logic             ex_memrd,
   input  logic             ex_regwrt,
   input  logic [REG_W-1:0] ex_write_reg,
   input  logic             mis_pred,
   input  logic             mem_halt,
   output logic             hold_ifid,
   output logic             hold_idex,
   output logic             hold_exmem,
   output logic             hold_memwb,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             flush_exmem,
   output logic             pc_hold,
   output logic             pc_redirect,
   output logic             halted,
   output logic             stall_timeout,
   output logic [1:0]       state_dbg
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [15:0]      perf_busy_cyc,
   output logic [15:0]      perf_luh_cyc,
   output logic [15:0]      perf_flush_cnt
`endif
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      REDIRECT = 2'd1,
      DRAIN    = 2'd2,
      HALTED   = 2'd3
   } state_e;

   localparam logic [3:0] DRAIN_INIT  = 4'(DRAIN_CYCLES);
   localparam logic [7:0] TIMEOUT_CNT = 8'(STALL_TIMEOUT);

   state_e     state_q, state_nxt;
   logic       pend_q, pend_nxt;
   logic [3:0] drain_q, drain_nxt;
   logic [7:0] busy_cnt, busy_cnt_nxt;
   logic       busy;
   logic       luh;

   assign busy = fetch_stall | mem_stall;
   assign luh  = ex_memrd & ex_regwrt &
                 ((id_rs_used & (id_rs == ex_write_reg)) |
                  (id_rt_used & (id_rt == ex_write_reg)));

   assign state_dbg = state_q;

   always_comb begin
      // NOTE: every output and next-state term gets a default first so no branch infers a latch.
      hold_ifid   = 1'b0;
      hold_idex   = 1'b0;
      hold_exmem  = 1'b0;
      hold_memwb  = 1'b0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      flush_exmem = 1'b0;
      pc_hold     = 1'b0;
      pc_redirect = 1'b0;
      state_nxt   = state_q;
      pend_nxt    = pend_q;
      drain_nxt   = drain_q;

      // Outputs are forced low for the whole time rst is high, not just after the flops clear.
      if (!rst) begin
         if (busy && (state_q != HALTED)) begin
            hold_ifid  = 1'b1;
            hold_idex  = 1'b1;
            hold_exmem = 1'b1;
            hold_memwb = 1'b1;
            pc_hold    = 1'b1;
            if (mis_pred) pend_nxt = 1'b1;
         end else begin
            unique case (state_q)
               RUN: begin
                  if (mis_pred || pend_q) begin
                     flush_ifid  = 1'b1;
                     flush_idex  = 1'b1;
                     flush_exmem = 1'b1;
                     pc_redirect = 1'b1;
                     pend_nxt    = 1'b0;
                     state_nxt   = REDIRECT;
                  end else if (mem_halt) begin
                     flush_ifid  = 1'b1;
                     flush_idex  = 1'b1;
                     flush_exmem = 1'b1;
                     pc_hold     = 1'b1;
                     drain_nxt   = DRAIN_INIT;
                     state_nxt   = DRAIN;
                  end else if (luh) begin
                     pc_hold    = 1'b1;
                     hold_ifid  = 1'b1;
                     flush_idex = 1'b1;
                  end
               end
               // ID holds a flushed bubble here, so a load-use match is not a real hazard.
               REDIRECT: begin
                  if (mis_pred || pend_q) begin
                     flush_ifid  = 1'b1;
                     flush_idex  = 1'b1;
                     flush_exmem = 1'b1;
                     pc_redirect = 1'b1;
                     pend_nxt    = 1'b0;
                     state_nxt   = REDIRECT;
                  end else begin
                     state_nxt = RUN;
                  end
               end
               DRAIN: begin
                  pc_hold     = 1'b1;
                  flush_ifid  = 1'b1;
                  flush_idex  = 1'b1;
                  flush_exmem = 1'b1;
                  drain_nxt   = drain_q - 4'd1;
                  if (drain_q <= 4'd1) state_nxt = HALTED;
               end
               HALTED: begin
                  hold_ifid  = 1'b1;
                  hold_idex  = 1'b1;
                  hold_exmem = 1'b1;
                  hold_memwb = 1'b1;
                  pc_hold    = 1'b1;
               end
            endcase
         end
      end
   end

   always_comb begin
      busy_cnt_nxt = 8'd0;
      if (busy) busy_cnt_nxt = (busy_cnt == 8'hFF) ? busy_cnt : busy_cnt + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= RUN;
         pend_q        <= 1'b0;
         drain_q       <= 4'd0;
         busy_cnt      <= 8'd0;
         halted        <= 1'b0;
         stall_timeout <= 1'b0;
      end else begin
         // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
         state_q  <= state_nxt;
         pend_q   <= pend_nxt;
         drain_q  <= drain_nxt;
         busy_cnt <= busy_cnt_nxt;
         if (busy && (busy_cnt_nxt == TIMEOUT_CNT)) stall_timeout <= 1'b1;
         if (state_q == HALTED) halted <= 1'b1;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic luh_taken;
   logic go_redir;

   assign luh_taken = !busy && (state_q == RUN) && !(mis_pred || pend_q) && !mem_halt && luh;
   assign go_redir  = !busy && ((state_q == RUN) || (state_q == REDIRECT)) && (mis_pred || pend_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_busy_cyc  <= 16'd0;
         perf_luh_cyc   <= 16'd0;
         perf_flush_cnt <= 16'd0;
      end else begin
         if (busy && (perf_busy_cyc != 16'hFFFF)) perf_busy_cyc <= perf_busy_cyc + 16'd1;
         if (luh_taken && (perf_luh_cyc != 16'hFFFF)) perf_luh_cyc <= perf_luh_cyc + 16'd1;
         if (go_redir && (perf_flush_cnt != 16'hFFFF)) perf_flush_cnt <= perf_flush_cnt + 16'd1;
      end
   end
`endif

   // A halt arriving together with a mispredict is dropped; flag it in simulation.
   a_halt_vs_mispred : assert property (@(posedge clk) disable iff (rst)
      !((state_q == RUN) && !busy && mis_pred && mem_halt));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected outputs, a monitor pops and compares.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

   localparam int REG_W = 3;

   typedef struct packed {
      logic [3:0] hold;     // {ifid, idex, exmem, memwb}
      logic [2:0] flush;    // {ifid, idex, exmem}
      logic       pc_hold;
      logic       pc_redirect;
      logic       halted;
      logic       stall_timeout;
      logic [1:0] state;
   } outs_t;

   typedef struct packed {
      logic       fetch_stall;
      logic       mem_stall;
      logic [2:0] id_rs;
      logic [2:0] id_rt;
      logic       id_rs_used;
      logic       id_rt_used;
      logic       ex_memrd;
      logic       ex_regwrt;
      logic [2:0] ex_write_reg;
      logic       mis_pred;
      logic       mem_halt;
   } in_t;

   logic             clk;
   logic             rst;
   logic             fetch_stall, mem_stall;
   logic [REG_W-1:0] id_rs, id_rt, ex_write_reg;
   logic             id_rs_used, id_rt_used, ex_memrd, ex_regwrt, mis_pred, mem_halt;
   logic             hold_ifid, hold_idex, hold_exmem, hold_memwb;
   logic             flush_ifid, flush_idex, flush_exmem;
   logic             pc_hold, pc_redirect, halted, stall_timeout;
   logic [1:0]       state_dbg;

   pipe_hazard_ctrl #(
      .REG_W(REG_W),
      .DRAIN_CYCLES(2),
      .STALL_TIMEOUT(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .fetch_stall(fetch_stall),
      .mem_stall(mem_stall),
      .id_rs(id_rs),
      .id_rt(id_rt),
      .id_rs_used(id_rs_used),
      .id_rt_used(id_rt_used),
      .ex_memrd(ex_memrd),
      .ex_regwrt(ex_regwrt),
      .ex_write_reg(ex_write_reg),
      .mis_pred(mis_pred),
      .mem_halt(mem_halt),
      .hold_ifid(hold_ifid),
      .hold_idex(hold_idex),
      .hold_exmem(hold_exmem),
      .hold_memwb(hold_memwb),
      .flush_ifid(flush_ifid),
      .flush_idex(flush_idex),
      .flush_exmem(flush_exmem),
      .pc_hold(pc_hold),
      .pc_redirect(pc_redirect),
      .halted(halted),
      .stall_timeout(stall_timeout),
      .state_dbg(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   outs_t exp_q[$];
   string name_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   logic  imm_tick = 1'b0;
   outs_t act;

   assign act = '{hold: {hold_ifid, hold_idex, hold_exmem, hold_memwb},
                  flush: {flush_ifid, flush_idex, flush_exmem},
                  pc_hold: pc_hold, pc_redirect: pc_redirect, halted: halted,
                  stall_timeout: stall_timeout, state: state_dbg};

   // Monitor: pops one expectation per falling edge, or immediately when an async check is posted.
   initial begin
      outs_t e;
      string nm;
      forever begin
         @(negedge clk or imm_tick);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (act !== e) begin
               n_bad++;
               $display("FAIL %s: got hold=%b flush=%b pch=%b pcr=%b hlt=%b tmo=%b st=%0d, want hold=%b flush=%b pch=%b pcr=%b hlt=%b tmo=%b st=%0d",
                        nm, act.hold, act.flush, act.pc_hold, act.pc_redirect, act.halted,
                        act.stall_timeout, act.state, e.hold, e.flush, e.pc_hold,
                        e.pc_redirect, e.halted, e.stall_timeout, e.state);
            end
         end
      end
   end

   function automatic outs_t o(input logic [3:0] h, input logic [2:0] f, input logic pch,
                               input logic pcr, input logic hlt, input logic tmo,
                               input logic [1:0] st);
      outs_t r;
      r.hold = h; r.flush = f; r.pc_hold = pch; r.pc_redirect = pcr;
      r.halted = hlt; r.stall_timeout = tmo; r.state = st;
      return r;
   endfunction

   function automatic in_t mk(input logic fs, input logic ms, input logic mp, input logic mh);
      in_t v;
      v = '0;
      v.fetch_stall = fs; v.mem_stall = ms; v.mis_pred = mp; v.mem_halt = mh;
      return v;
   endfunction

   function automatic in_t lu(input logic [2:0] rs, input logic [2:0] rt, input logic rsu,
                              input logic rtu, input logic memrd, input logic regwrt,
                              input logic [2:0] wr);
      in_t v;
      v = '0;
      v.id_rs = rs; v.id_rt = rt; v.id_rs_used = rsu; v.id_rt_used = rtu;
      v.ex_memrd = memrd; v.ex_regwrt = regwrt; v.ex_write_reg = wr;
      return v;
   endfunction

   task automatic apply(input in_t v);
      fetch_stall  = v.fetch_stall;
      mem_stall    = v.mem_stall;
      id_rs        = v.id_rs;
      id_rt        = v.id_rt;
      id_rs_used   = v.id_rs_used;
      id_rt_used   = v.id_rt_used;
      ex_memrd     = v.ex_memrd;
      ex_regwrt    = v.ex_regwrt;
      ex_write_reg = v.ex_write_reg;
      mis_pred     = v.mis_pred;
      mem_halt     = v.mem_halt;
   endtask

   task automatic step(input in_t v, input outs_t e, input string nm);
      @(posedge clk);
      #1;
      apply(v);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Raises rst between edges and expects every output low before any clock edge.
   task automatic async_rst(input in_t v, input string nm);
      @(posedge clk);
      #2;
      apply(v);
      rst = 1'b1;
      #1;
      exp_q.push_back(o(4'b0000, 3'b000, 0, 0, 0, 0, 2'd0));
      name_q.push_back(nm);
      imm_tick = ~imm_tick;
      @(negedge clk);
      #1;
      rst = 1'b0;
      apply('0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      outs_t z, bsy, lh, rd, dr, hl;
      in_t   v;
      z   = o(4'b0000, 3'b000, 0, 0, 0, 0, 2'd0);
      bsy = o(4'b1111, 3'b000, 1, 0, 0, 0, 2'd0);
      lh  = o(4'b1000, 3'b010, 1, 0, 0, 0, 2'd0);
      rd  = o(4'b0000, 3'b111, 0, 1, 0, 0, 2'd0);
      dr  = o(4'b0000, 3'b111, 1, 0, 0, 0, 2'd2);
      hl  = o(4'b1111, 3'b000, 1, 0, 0, 0, 2'd3);

      // Reset state, with a busy input present to show outputs are gated.
      rst = 1'b1;
      apply(mk(0, 1, 0, 0));
      #3;
      exp_q.push_back(z);
      name_q.push_back("reset_busy");
      imm_tick = ~imm_tick;
      #9;
      rst = 1'b0;
      apply('0);

      // Load-use hazard patterns.
      step(lu(3, 0, 1, 0, 1, 1, 3), lh, "luh_rs");
      step(lu(3, 0, 1, 0, 0, 1, 3), z, "luh_not_load");
      step(lu(1, 5, 1, 1, 1, 1, 5), lh, "luh_rt");
      step(lu(1, 5, 1, 0, 1, 1, 5), z, "luh_rt_unused");
      step(lu(3, 3, 1, 1, 1, 0, 3), z, "luh_no_regwrt");

      // Mispredict while stalled: remembered and consumed on the first free cycle.
      step(mk(0, 1, 0, 0), bsy, "stall_c1");
      step(mk(0, 1, 1, 0), bsy, "stall_c2_mp");
      step(mk(0, 1, 0, 0), bsy, "stall_c3");
      step(mk(1, 0, 0, 0), bsy, "stall_c4_fetch");
      step(mk(0, 0, 0, 0), rd, "pend_redirect");
      step(mk(0, 0, 0, 0), o(4'b0000, 3'b000, 0, 0, 0, 0, 2'd1), "redirect_state");
      step(mk(0, 0, 0, 0), z, "back_to_run");

      // Mispredict beats load-use; REDIRECT suppresses the hazard and can be re-entered.
      v = lu(3, 0, 1, 0, 1, 1, 3);
      v.mis_pred = 1'b1;
      step(v, rd, "mp_over_luh");
      step(lu(3, 0, 1, 0, 1, 1, 3), o(4'b0000, 3'b000, 0, 0, 0, 0, 2'd1), "redirect_no_luh");
      step(mk(0, 0, 0, 0), z, "run_after_redir");
      step(mk(0, 0, 1, 0), rd, "mp_again");
      step(mk(0, 0, 1, 0), o(4'b0000, 3'b111, 0, 1, 0, 0, 2'd1), "mp_in_redirect");
      step(mk(0, 0, 0, 0), o(4'b0000, 3'b000, 0, 0, 0, 0, 2'd1), "redirect_reentered");
      step(mk(0, 0, 0, 0), z, "run_after_reentry");

      // Stall timeout at 8 busy edges, sticky until an async reset.
      for (int k = 1; k <= 10; k++) begin
         step(mk(0, 1, 0, 0), o(4'b1111, 3'b000, 1, 0, 0, (k > 8) ? 1'b1 : 1'b0, 2'd0), "timeout_busy");
      end
      step(mk(0, 0, 0, 0), o(4'b0000, 3'b000, 0, 0, 0, 1, 2'd0), "timeout_sticky1");
      step(mk(0, 0, 0, 0), o(4'b0000, 3'b000, 0, 0, 0, 1, 2'd0), "timeout_sticky2");
      async_rst(mk(0, 1, 0, 0), "timeout_async_clear");
      step(mk(0, 0, 0, 0), z, "after_timeout_reset");

      // Halt drain with a fetch stall in the second drain cycle.
      step(mk(0, 0, 0, 1), o(4'b0000, 3'b111, 1, 0, 0, 0, 2'd0), "halt_in_mem");
      step(mk(0, 0, 0, 0), dr, "drain_1");
      step(mk(1, 0, 0, 0), o(4'b1111, 3'b000, 1, 0, 0, 0, 2'd2), "drain_busy");
      step(mk(0, 0, 0, 0), dr, "drain_2");
      step(mk(0, 0, 0, 0), hl, "halted_entry");
      hl.halted = 1'b1;
      step(mk(0, 0, 1, 0), hl, "halted_mp_ignored");
      step(mk(0, 1, 0, 0), hl, "halted_busy_ignored");
      step(mk(0, 0, 0, 0), hl, "halted_sticky");
      async_rst(mk(0, 0, 0, 0), "halted_async_clear");
      step(mk(0, 0, 0, 0), z, "after_halt_reset");

      // Reset during DRAIN with drain_cnt=1.
      step(mk(0, 0, 0, 1), o(4'b0000, 3'b111, 1, 0, 0, 0, 2'd0), "halt2_in_mem");
      step(mk(0, 0, 0, 0), dr, "drain2_1");
      async_rst(mk(0, 0, 0, 0), "drain_async_reset");
      step(mk(0, 0, 0, 0), z, "after_drain_reset");

      repeat (2) @(posedge clk);
      if (exp_q.size() != 0) begin
         $display("FAIL scoreboard_drain: got %0d pending expectations, want 0", exp_q.size());
         n_cmp += exp_q.size();
         n_bad += exp_q.size();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
